irq_ctrl: RTL and testbench

- Parametrised successor to the fixed 4-line interrupt inputs and `interrupt_N_clr` outputs of the current CPU.
- Accepts NUM_IRQ external requests and synchronises them.
- Per channel: latches requests as edge- or level-triggered, applies an enable mask, resolves fixed priority with nesting, and hands the CPU control unit a request, a vector address and an acknowledge/return handshake.
- Configuration and status registers are memory-mapped on the 8-bit data/IO bus.

---
 rtl/irq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//
// Parametrised interrupt controller for the CPU control unit. Up to eight
// asynchronous peripheral request lines are synchronised, latched per channel
// as edge- or level-triggered requests, masked by ENABLE, and resolved with
// fixed priority (channel 0 highest) and nesting. The winner is presented to
// the CPU as a request plus a vector address; the CPU answers with an
// acknowledge (vector fetch) and later a return-from-interrupt strobe.
//
// Ports
//   clk         in   1        system clock, rising edge
//   reset       in   1        asynchronous reset, active low
//   irq_in      in   NUM_IRQ  raw peripheral requests (asynchronous)
//   irq_clr     out  NUM_IRQ  one-cycle pulse to the source on acknowledge
//   io_addr     in   3        register select
//   io_wdata    in   8        register write data
//   io_we       in   1        register write strobe
//   io_re       in   1        register read strobe
//   io_rdata    out  8        registered read data (one-cycle latency)
//   irq_req     out  1        request to the CPU
//   irq_vector  out  16       vector address of the winning channel
//   irq_ack     in   1        CPU takes the interrupt this cycle
//   irq_done    in   1        CPU executed return-from-interrupt
//   cpu_ie      in   1        CPU global interrupt enable
//
// CPU handshake: irq_req/irq_vector are a valid pair derived only from
// registered state, so they are stable within a cycle. The transfer happens
// on a rising clk edge where irq_req=1 and irq_ack=1; an irq_ack seen while
// irq_req=0 is ignored. irq_done is an independent strobe that retires the
// highest-priority in-service channel; when it coincides with an accepted
// irq_ack, the retire is applied first and the new in-service bit second.
//
// Register map (bits at and above NUM_IRQ read 0, writes ignored)
//   0 ENABLE     R/W
//   1 MODE       R/W, 1 = edge, 0 = level
//   2 PENDING    R, write-1-to-clear
//   3 INSERVICE  R
//   4 ACTIVE     R, {4'b0, valid, id[2:0]} of highest in-service channel
//   5 SWSET      W, write-1 sets pending; reads 0
//   6,7          read 0
// -----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int          NUM_IRQ       = 8,        // 1..8
    parameter logic [15:0] VECTOR_BASE   = 16'h0002,
    parameter int          VECTOR_STRIDE = 2,
    parameter int          SYNC_STAGES   = 2         // 2..3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_clr,
    input  logic [2:0]         io_addr,
    input  logic [7:0]         io_wdata,
    input  logic               io_we,
    input  logic               io_re,
    output logic [7:0]         io_rdata,
    output logic               irq_req,
    output logic [15:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               irq_done,
    input  logic               cpu_ie
);

    localparam logic [2:0] ADDR_ENABLE    = 3'd0;
    localparam logic [2:0] ADDR_MODE      = 3'd1;
    localparam logic [2:0] ADDR_PENDING   = 3'd2;
    localparam logic [2:0] ADDR_INSERVICE = 3'd3;
    localparam logic [2:0] ADDR_ACTIVE    = 3'd4;
    localparam logic [2:0] ADDR_SWSET     = 3'd5;

    // -------------------------------------------------------------------------
    // Input synchroniser
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_s;      // synchronised line value
    logic [NUM_IRQ-1:0] sync_d_q;    // synchronised value, one cycle older

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] mode_q,   mode_d;
    // pend_q holds the pending flag of an edge channel and the software-set
    // latch of a level channel. Both are set by SWSET, cleared by W1C and by
    // acknowledge, so a single register serves both interpretations.
    logic [NUM_IRQ-1:0] pend_q,   pend_d;
    logic [NUM_IRQ-1:0] isv_q,    isv_d;
    logic [NUM_IRQ-1:0] clr_q,    clr_d;
    logic [7:0]         rdata_q,  rdata_d;

    // -------------------------------------------------------------------------
    // Pending view, candidates and priority resolution
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] cand;

    assign wdata_n  = io_wdata[NUM_IRQ-1:0];
    // Level channels follow the synchronised line, ORed with their latch.
    assign pending  = pend_q | (~mode_q & sync_s);
    assign edge_set = mode_q & sync_s & ~sync_d_q;
    assign cand     = pending & enable_q;

    logic               win_any;
    logic [3:0]         win_idx;
    logic [NUM_IRQ-1:0] win_oh;

    // Lowest index wins; scanning downwards leaves the lowest hit last.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        win_oh  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_any    = 1'b1;
                win_idx    = 4'(i);
                win_oh     = '0;
                win_oh[i]  = 1'b1;
            end
        end
    end

    logic               lvl_any;
    logic [3:0]         lvl_idx;     // NUM_IRQ when nothing is in service
    logic [NUM_IRQ-1:0] lvl_oh;

    always_comb begin
        lvl_any = 1'b0;
        lvl_idx = 4'(NUM_IRQ);
        lvl_oh  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (isv_q[i]) begin
                lvl_any    = 1'b1;
                lvl_idx    = 4'(i);
                lvl_oh     = '0;
                lvl_oh[i]  = 1'b1;
            end
        end
    end

    logic take;

    // Only a strictly higher-priority channel may preempt the active level.
    assign irq_req    = cpu_ie & win_any & (win_idx < lvl_idx);
    // With no candidate win_idx is 0, so the vector rests at VECTOR_BASE.
    assign irq_vector = VECTOR_BASE + (16'(win_idx) * 16'(VECTOR_STRIDE));
    assign take       = irq_ack & irq_req;

    // -------------------------------------------------------------------------
    // Register read mux (values before this cycle's update)
    // -------------------------------------------------------------------------
    logic [7:0] rd_val;

    always_comb begin
        rd_val = '0;
        case (io_addr)
            ADDR_ENABLE:    rd_val[NUM_IRQ-1:0] = enable_q;
            ADDR_MODE:      rd_val[NUM_IRQ-1:0] = mode_q;
            ADDR_PENDING:   rd_val[NUM_IRQ-1:0] = pending;
            ADDR_INSERVICE: rd_val[NUM_IRQ-1:0] = isv_q;
            ADDR_ACTIVE:    rd_val = {4'b0000, lvl_any, lvl_idx[2:0]};
            default:        rd_val = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        pend_d   = pend_q;
        isv_d    = isv_q;
        clr_d    = '0;
        rdata_d  = rdata_q;

        if (io_we && io_addr == ADDR_ENABLE) begin
            enable_d = wdata_n;
        end
        if (io_we && io_addr == ADDR_MODE) begin
            mode_d = wdata_n;
        end

        // Clears first, then sets: a set on the same cycle wins.
        if (io_we && io_addr == ADDR_PENDING) begin
            pend_d = pend_d & ~wdata_n;
        end
        if (take) begin
            pend_d = pend_d & ~win_oh;
        end
        pend_d = pend_d | edge_set;
        if (io_we && io_addr == ADDR_SWSET) begin
            pend_d = pend_d | wdata_n;
        end

        // Retire before accept so a coincident done/ack pair both take effect.
        if (irq_done) begin
            isv_d = isv_d & ~lvl_oh;
        end
        if (take) begin
            isv_d = isv_d | win_oh;
            clr_d = win_oh;
        end

        if (io_re) begin
            rdata_d = rd_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_d_q <= '0;
            enable_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            isv_q    <= '0;
            clr_q    <= '0;
            rdata_q  <= '0;
        end else begin
            sync_d_q <= sync_s;
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            isv_q    <= isv_d;
            clr_q    <= clr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign irq_clr  = clr_q;
    assign io_rdata = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
//
// Directed scenarios followed by randomised operations. A behavioural model
// of the controller (register contents, line levels, in-service set) produces
// expected values; read data, request/vector probes and irq_clr pulses are
// pushed into queues and compared by independent monitors on the falling edge.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

    localparam int NUM_IRQ = 8;
    localparam int SYNC    = 2;
    localparam int SETTLE  = SYNC + 2;

    // ---------------------------------------------------------------- clock/reset
    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_IRQ-1:0] irq_in = '0;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [2:0]         io_addr = '0;
    logic [7:0]         io_wdata = '0;
    logic               io_we = 1'b0;
    logic               io_re = 1'b0;
    logic [7:0]         io_rdata;
    logic               irq_req;
    logic [15:0]        irq_vector;
    logic               irq_ack = 1'b0;
    logic               irq_done = 1'b0;
    logic               cpu_ie = 1'b0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_IRQ      (NUM_IRQ),
        .VECTOR_BASE  (16'h0002),
        .VECTOR_STRIDE(2),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .irq_clr   (irq_clr),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_we     (io_we),
        .io_re     (io_re),
        .io_rdata  (io_rdata),
        .irq_req   (irq_req),
        .irq_vector(irq_vector),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done),
        .cpu_ie    (cpu_ie)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]         rd_q  [$];
    logic [16:0]        req_q [$];
    logic [NUM_IRQ-1:0] clr_q [$];

    logic rd_valid;
    logic probe = 1'b0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) rd_valid <= 1'b0;
        else        rd_valid <= io_re;
    end

    always @(negedge clk) begin : mon_rd
        logic [7:0] e;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                check("io_rdata_unexpected", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                check("io_rdata", 32'(io_rdata), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_req
        logic [16:0] e;
        if (probe) begin
            if (req_q.size() == 0) begin
                check("probe_unexpected", 32'd1, 32'd0);
            end else begin
                e = req_q.pop_front();
                check("irq_req_vector", 32'({irq_req, irq_vector}), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_clr
        logic [NUM_IRQ-1:0] e;
        if (irq_clr != '0) begin
            if (clr_q.size() == 0) begin
                check("irq_clr_unexpected", 32'(irq_clr), 32'd0);
            end else begin
                e = clr_q.pop_front();
                check("irq_clr", 32'(irq_clr), 32'(e));
            end
        end
    end

    // ---------------------------------------------------------------- reference model
    logic [7:0] m_en, m_mode, m_epend, m_sw, m_line, m_isv;
    logic       m_ie;

    function automatic logic [7:0] m_pending();
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (m_mode[i]) p[i] = m_epend[i];
            else           p[i] = m_line[i] | m_sw[i];
        end
        return p;
    endfunction

    function automatic int m_winner();
        logic [7:0] c;
        c = m_pending() & m_en;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (c[i]) return i;
        end
        return -1;
    endfunction

    function automatic int m_level();
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (m_isv[i]) return i;
        end
        return NUM_IRQ;
    endfunction

    function automatic logic m_req();
        int w;
        w = m_winner();
        return m_ie && (w >= 0) && (w < m_level());
    endfunction

    function automatic logic [15:0] m_vec();
        int w;
        w = m_winner();
        if (w < 0) return 16'h0002;
        return 16'h0002 + 16'(w * 2);
    endfunction

    function automatic logic [7:0] m_reg(input logic [2:0] a);
        int lvl;
        case (a)
            3'd0: return m_en;
            3'd1: return m_mode;
            3'd2: return m_pending();
            3'd3: return m_isv;
            3'd4: begin
                lvl = m_level();
                if (lvl < NUM_IRQ) return 8'h08 | 8'(lvl);
                return 8'h00;
            end
            default: return 8'h00;
        endcase
    endfunction

    function void m_reset();
        m_en = '0; m_mode = '0; m_epend = '0; m_sw = '0; m_isv = '0;
    endfunction

    function void m_write(input logic [2:0] a, input logic [7:0] d);
        case (a)
            3'd0: m_en   = d;
            3'd1: m_mode = d;
            3'd2: for (int i = 0; i < NUM_IRQ; i++) begin
                      if (d[i]) begin
                          if (m_mode[i]) m_epend[i] = 1'b0;
                          else           m_sw[i]    = 1'b0;
                      end
                  end
            3'd5: for (int i = 0; i < NUM_IRQ; i++) begin
                      if (d[i]) begin
                          if (m_mode[i]) m_epend[i] = 1'b1;
                          else           m_sw[i]    = 1'b1;
                      end
                  end
            default: ;
        endcase
    endfunction

    function void m_retire();
        int lvl;
        lvl = m_level();
        if (lvl < NUM_IRQ) m_isv[lvl] = 1'b0;
    endfunction

    // ---------------------------------------------------------------- driver tasks
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        io_addr = a; io_wdata = d; io_we = 1'b1;
        @(posedge clk); #1;
        io_we = 1'b0;
        m_write(a, d);
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp_v);
        @(posedge clk); #1;
        io_addr = a; io_re = 1'b1;
        rd_q.push_back(exp_v);
        @(posedge clk); #1;
        io_re = 1'b0;
    endtask

    // Write and read the same register in one cycle; read returns the old value.
    task automatic wr_rd(input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp_old);
        @(posedge clk); #1;
        io_addr = a; io_wdata = d; io_we = 1'b1; io_re = 1'b1;
        rd_q.push_back(exp_old);
        @(posedge clk); #1;
        io_we = 1'b0; io_re = 1'b0;
        m_write(a, d);
    endtask

    task automatic probe_req(input logic req, input logic [15:0] vec);
        @(posedge clk); #1;
        probe = 1'b1;
        req_q.push_back({req, vec});
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic set_line(input int ch, input logic v);
        @(posedge clk); #1;
        irq_in[ch] = v;
        if (v && !m_line[ch] && m_mode[ch]) m_epend[ch] = 1'b1;
        m_line[ch] = v;
        repeat (SETTLE) @(posedge clk);
    endtask

    task automatic pulse(input int ch);
        set_line(ch, 1'b1);
        set_line(ch, 1'b0);
    endtask

    task automatic set_ie(input logic v);
        @(posedge clk); #1;
        cpu_ie = v;
        m_ie   = v;
    endtask

    task automatic do_ack(input logic with_done);
        logic pre_req;
        int   w;
        pre_req = m_req();
        w       = m_winner();
        @(posedge clk); #1;
        irq_ack  = 1'b1;
        irq_done = with_done;
        if (with_done) m_retire();
        if (pre_req) begin
            m_isv[w] = 1'b1;
            if (m_mode[w]) m_epend[w] = 1'b0;
            else           m_sw[w]    = 1'b0;
            clr_q.push_back(NUM_IRQ'(1) << w);
        end
        @(posedge clk); #1;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
    endtask

    task automatic do_done();
        @(posedge clk); #1;
        irq_done = 1'b1;
        m_retire();
        @(posedge clk); #1;
        irq_done = 1'b0;
    endtask

    task automatic sync_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_reset();
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- main sequence
    initial begin : main
        int lat;
        logic found;
        logic [2:0] a;
        int ch, op;

        m_reset();
        m_line = '0;
        m_ie   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq_req", 32'(irq_req), 32'd0);
        check("rst_irq_vector", 32'(irq_vector), 32'h0002);
        check("rst_irq_clr", 32'(irq_clr), 32'd0);
        check("rst_io_rdata", 32'(io_rdata), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) rd(3'(i), 8'h00);

        // Edge request on channel 0, latency and acknowledge
        wr(3'd0, 8'h01);
        wr(3'd1, 8'h01);
        set_ie(1'b1);
        @(posedge clk); #1;
        irq_in[0] = 1'b1;
        m_line[0] = 1'b1;
        m_epend[0] = 1'b1;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (irq_req) found = 1'b1;
        end
        check("irq_latency_in_bound", 32'(found && lat <= SYNC + 1), 32'd1);
        repeat (2) @(posedge clk);
        probe_req(1'b1, 16'h0002);
        do_ack(1'b0);
        rd(3'd2, 8'h00);
        rd(3'd3, 8'h01);
        probe_req(1'b0, 16'h0002);
        set_line(0, 1'b0);
        do_done();
        rd(3'd3, 8'h00);

        // Nesting: channel 3 preempts channel 5
        wr(3'd0, 8'h28);
        wr(3'd1, 8'h28);
        pulse(5);
        probe_req(1'b1, 16'h000C);
        do_ack(1'b0);
        rd(3'd3, 8'h20);
        pulse(3);
        probe_req(1'b1, 16'h0008);
        do_ack(1'b0);
        rd(3'd3, 8'h28);
        rd(3'd4, 8'h0B);
        do_done();
        rd(3'd3, 8'h20);
        rd(3'd4, 8'h0D);
        do_done();
        rd(3'd3, 8'h00);
        rd(3'd4, 8'h00);

        // Lower priority waits for return
        wr(3'd0, 8'h44);
        wr(3'd1, 8'h44);
        pulse(2);
        do_ack(1'b0);
        pulse(6);
        probe_req(1'b0, 16'h000E);
        rd(3'd2, 8'h40);
        do_done();
        probe_req(1'b1, 16'h000E);
        do_ack(1'b0);
        rd(3'd3, 8'h40);
        do_done();
        rd(3'd3, 8'h00);

        // Level mode
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h02);
        set_line(1, 1'b1);
        probe_req(1'b1, 16'h0004);
        do_ack(1'b0);
        probe_req(1'b0, 16'h0004);
        rd(3'd2, 8'h02);
        do_done();
        probe_req(1'b1, 16'h0004);
        do_ack(1'b1);               // done with nothing in service, ack applies
        rd(3'd3, 8'h02);
        do_done();
        set_line(1, 1'b0);
        rd(3'd2, 8'h00);
        probe_req(1'b0, 16'h0002);

        // Software set / clear and global enable
        wr(3'd0, 8'h04);
        wr(3'd5, 8'h04);
        rd(3'd2, 8'h04);
        rd(3'd5, 8'h00);
        probe_req(1'b1, 16'h0006);
        wr(3'd2, 8'h04);
        probe_req(1'b0, 16'h0002);
        rd(3'd2, 8'h00);
        set_ie(1'b0);
        wr(3'd5, 8'h04);
        probe_req(1'b0, 16'h0006);
        do_ack(1'b0);               // ignored: no request
        rd(3'd3, 8'h00);
        set_ie(1'b1);
        probe_req(1'b1, 16'h0006);
        wr(3'd2, 8'h04);
        wr_rd(3'd0, 8'hFF, 8'h04);
        rd(3'd0, 8'hFF);
        repeat (2) @(posedge clk);
        #1 check("io_rdata_hold", 32'(io_rdata), 32'h00FF);
        rd(3'd6, 8'h00);
        rd(3'd7, 8'h00);
        wr(3'd0, 8'h00);

        // Asynchronous reset in the middle of a handler
        wr(3'd0, 8'h03);
        wr(3'd1, 8'h03);
        pulse(1);
        do_ack(1'b0);
        rd(3'd3, 8'h02);
        pulse(0);
        probe_req(1'b1, 16'h0002);
        rd(3'd0, 8'h03);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_rst_irq_req", 32'(irq_req), 32'd0);
        check("async_rst_irq_clr", 32'(irq_clr), 32'd0);
        check("async_rst_io_rdata", 32'(io_rdata), 32'd0);
        check("async_rst_irq_vector", 32'(irq_vector), 32'h0002);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_reset();
        rd(3'd0, 8'h00);
        rd(3'd2, 8'h00);
        rd(3'd3, 8'h00);
        probe_req(1'b0, 16'h0002);

        // Randomised operations against the model
        sync_reset();
        wr(3'd1, 8'($urandom_range(0, 255)));
        wr(3'd0, 8'($urandom_range(0, 255)));
        set_ie(1'b1);
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 11);
            ch = $urandom_range(0, NUM_IRQ - 1);
            case (op)
                0, 1, 2: set_line(ch, ~m_line[ch]);
                3:       wr(3'd0, 8'($urandom_range(0, 255)));
                4:       wr(3'd5, 8'(1 << ch));
                5:       wr(3'd2, 8'($urandom_range(0, 255)));
                6, 7, 8: do_ack($urandom_range(0, 3) == 0);
                9:       do_done();
                10: begin
                    a = 3'($urandom_range(0, 7));
                    rd(a, m_reg(a));
                end
                default: set_ie(($urandom_range(0, 3) != 0));
            endcase
            probe_req(m_req(), m_vec());
            if (n % 4 == 0) rd(3'd3, m_reg(3'd3));
        end

        // Drain and final report
        repeat (4) @(posedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("irq_clr_missing", 32'(clr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
